// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath widths and control encodings
//
// Purpose: common types for the pipelined MIPS datapath.
// Contents: word_t (32), regbits_t (5), aluop_t, pcselect_t, wdatselect_t.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    PC_NEXT = 3'd0,
    PC_BEQ  = 3'd1,
    PC_BNE  = 3'd2,
    PC_J    = 3'd3,
    PC_JR   = 3'd4
  } pcselect_t;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_NPC = 2'd2,
    WD_LUI = 2'd3
  } wdatselect_t;

endpackage

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage with forwarding, ALU, branch resolve and EX/MEM latch
//
// Purpose: forwards operands, runs the ALU, resolves branch/jump redirects and
// registers everything into the EX/MEM latch owned by this block.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   enable, flush            EX/MEM load enable and bubble insert from the hazard unit
//   *_in                     ID/EX latch outputs (data and controls)
//   fwd_a_sel, fwd_b_sel     operand source select (0/3 rdat, 1 exmem_fwd, 2 memwb_fwd)
//   exmem_fwd, memwb_fwd     forwarded results
//   *_out                    EX/MEM latch outputs
//   redirect_out, target_out registered taken-branch/jump flag and PC
module execute_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        flush,
  input  word_t       imemload_in,
  input  word_t       npc_in,
  input  word_t       rdat1_in,
  input  word_t       rdat2_in,
  input  word_t       immediate_in,
  input  word_t       lui_word_in,
  input  logic        alusrc_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        WEN_in,
  input  logic        halt_in,
  input  aluop_t      aluop_in,
  input  regbits_t    wsel_in,
  input  wdatselect_t wdatsel_in,
  input  pcselect_t   pc_select_in,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  word_t       exmem_fwd,
  input  word_t       memwb_fwd,
  output word_t       alu_result_out,
  output word_t       store_data_out,
  output word_t       npc_out,
  output word_t       imemload_out,
  output word_t       lui_word_out,
  output logic        dREN_out,
  output logic        dWEN_out,
  output logic        WEN_out,
  output logic        halt_out,
  output regbits_t    wsel_out,
  output wdatselect_t wdatsel_out,
  output logic        redirect_out,
  output word_t       target_out
);

  word_t opa_d, rt_d, opb_d, alu_result_d, target_d;
  logic  redirect_d;

  word_t       alu_result_q, store_data_q, npc_q, imemload_q, lui_word_q, target_q;
  logic        dren_q, dwen_q, wen_q, halt_q, redirect_q;
  regbits_t    wsel_q;
  wdatselect_t wdatsel_q;

  always_comb begin
    opa_d = rdat1_in;
    case (fwd_a_sel)
      2'd1:    opa_d = exmem_fwd;
      2'd2:    opa_d = memwb_fwd;
      default: opa_d = rdat1_in;
    endcase
    rt_d = rdat2_in;
    case (fwd_b_sel)
      2'd1:    rt_d = exmem_fwd;
      2'd2:    rt_d = memwb_fwd;
      default: rt_d = rdat2_in;
    endcase
    opb_d = alusrc_in ? immediate_in : rt_d;
  end

  always_comb begin
    alu_result_d = '0;
    case (aluop_in)
      ALU_SLL:  alu_result_d = opb_d << opa_d[4:0];
      ALU_SRL:  alu_result_d = opb_d >> opa_d[4:0];
      ALU_ADD:  alu_result_d = opa_d + opb_d;
      ALU_SUB:  alu_result_d = opa_d - opb_d;
      ALU_AND:  alu_result_d = opa_d & opb_d;
      ALU_OR:   alu_result_d = opa_d | opb_d;
      ALU_XOR:  alu_result_d = opa_d ^ opb_d;
      ALU_NOR:  alu_result_d = ~(opa_d | opb_d);
      ALU_SLT:  alu_result_d = {31'd0, $signed(opa_d) < $signed(opb_d)};
      ALU_SLTU: alu_result_d = {31'd0, opa_d < opb_d};
      default:  alu_result_d = '0;
    endcase
  end

  // Branches compare against forwarded rt, never the immediate-muxed operand B.
  always_comb begin
    redirect_d = 1'b0;
    target_d   = npc_in + (immediate_in << 2);
    case (pc_select_in)
      PC_BEQ: redirect_d = (opa_d == rt_d);
      PC_BNE: redirect_d = (opa_d != rt_d);
      PC_J: begin
        redirect_d = 1'b1;
        target_d   = {npc_in[31:28], imemload_in[25:0], 2'b00};
      end
      PC_JR: begin
        redirect_d = 1'b1;
        target_d   = opa_d;
      end
      default: redirect_d = 1'b0;
    endcase
  end

  // Priority: reset, sticky halt freeze, flush (controls only), load, hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      npc_q        <= '0;
      imemload_q   <= '0;
      lui_word_q   <= '0;
      target_q     <= '0;
      dren_q       <= 1'b0;
      dwen_q       <= 1'b0;
      wen_q        <= 1'b0;
      halt_q       <= 1'b0;
      redirect_q   <= 1'b0;
      wsel_q       <= '0;
      wdatsel_q    <= WD_ALU;
    end else if (halt_q) begin
      // frozen until reset
    end else if (flush) begin
      dren_q     <= 1'b0;
      dwen_q     <= 1'b0;
      wen_q      <= 1'b0;
      halt_q     <= 1'b0;
      redirect_q <= 1'b0;
    end else if (enable) begin
      alu_result_q <= alu_result_d;
      store_data_q <= rt_d;
      npc_q        <= npc_in;
      imemload_q   <= imemload_in;
      lui_word_q   <= lui_word_in;
      target_q     <= target_d;
      dren_q       <= dREN_in;
      dwen_q       <= dWEN_in;
      wen_q        <= WEN_in;
      halt_q       <= halt_in;
      redirect_q   <= redirect_d;
      wsel_q       <= wsel_in;
      wdatsel_q    <= wdatsel_in;
    end
  end

  assign alu_result_out = alu_result_q;
  assign store_data_out = store_data_q;
  assign npc_out        = npc_q;
  assign imemload_out   = imemload_q;
  assign lui_word_out   = lui_word_q;
  assign target_out     = target_q;
  assign dREN_out       = dren_q;
  assign dWEN_out       = dwen_q;
  assign WEN_out        = wen_q;
  assign halt_out       = halt_q;
  assign redirect_out   = redirect_q;
  assign wsel_out       = wsel_q;
  assign wdatsel_out    = wdatsel_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized self-checking bench for execute_stage
module tb_execute_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, enable, flush;
  word_t       imemload_in, npc_in, rdat1_in, rdat2_in, immediate_in, lui_word_in;
  logic        alusrc_in, dREN_in, dWEN_in, WEN_in, halt_in;
  aluop_t      aluop_in;
  regbits_t    wsel_in;
  wdatselect_t wdatsel_in;
  pcselect_t   pc_select_in;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  word_t       exmem_fwd, memwb_fwd;
  word_t       alu_result_out, store_data_out, npc_out, imemload_out, lui_word_out, target_out;
  logic        dREN_out, dWEN_out, WEN_out, halt_out, redirect_out;
  regbits_t    wsel_out;
  wdatselect_t wdatsel_out;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
    .imemload_in(imemload_in), .npc_in(npc_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in),
    .immediate_in(immediate_in), .lui_word_in(lui_word_in), .alusrc_in(alusrc_in),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .WEN_in(WEN_in), .halt_in(halt_in),
    .aluop_in(aluop_in), .wsel_in(wsel_in), .wdatsel_in(wdatsel_in),
    .pc_select_in(pc_select_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .exmem_fwd(exmem_fwd), .memwb_fwd(memwb_fwd),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .npc_out(npc_out),
    .imemload_out(imemload_out), .lui_word_out(lui_word_out), .dREN_out(dREN_out),
    .dWEN_out(dWEN_out), .WEN_out(WEN_out), .halt_out(halt_out), .wsel_out(wsel_out),
    .wdatsel_out(wdatsel_out), .redirect_out(redirect_out), .target_out(target_out)
  );

  always #5 CLK = ~CLK;

  // Reference state of the EX/MEM latch.
  word_t m_alu, m_sd, m_npc, m_iml, m_lui, m_tgt;
  logic  m_dren, m_dwen, m_wen, m_halt, m_redir;
  logic [4:0] m_wsel;
  logic [1:0] m_wdatsel;
  bit    m_data_ok, m_tgt_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic word_t pick(input logic [1:0] sel, input word_t rd, input word_t ex, input word_t mw);
    if (sel == 2'd1) return ex;
    if (sel == 2'd2) return mw;
    return rd;
  endfunction

  function automatic word_t alu_ref(input aluop_t op, input word_t a, input word_t b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << (a % 32);
      ALU_SRL:  return b >> (a % 32);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    word_t a, rt, b, br_tgt;
    bit taken;
    a  = pick(fwd_a_sel, rdat1_in, exmem_fwd, memwb_fwd);
    rt = pick(fwd_b_sel, rdat2_in, exmem_fwd, memwb_fwd);
    b  = alusrc_in ? immediate_in : rt;
    br_tgt = npc_in + immediate_in * 4;
    if (RST) begin
      {m_alu, m_sd, m_npc, m_iml, m_lui, m_tgt} = '0;
      {m_dren, m_dwen, m_wen, m_halt, m_redir} = '0;
      m_wsel = '0;
      m_wdatsel = '0;
      m_data_ok = 1;
      m_tgt_ok = 1;
    end else if (m_halt) begin
    end else if (flush) begin
      {m_dren, m_dwen, m_wen, m_halt, m_redir} = '0;
      m_data_ok = 0;
      m_tgt_ok = 0;
    end else if (enable) begin
      m_alu = alu_ref(aluop_in, a, b);
      m_sd = rt;
      m_npc = npc_in;
      m_iml = imemload_in;
      m_lui = lui_word_in;
      m_dren = dREN_in;
      m_dwen = dWEN_in;
      m_wen = WEN_in;
      m_halt = halt_in;
      m_wsel = wsel_in;
      m_wdatsel = wdatsel_in;
      m_data_ok = 1;
      taken = 0;
      m_tgt = br_tgt;
      case (pc_select_in)
        PC_BEQ: taken = (a == rt);
        PC_BNE: taken = (a != rt);
        PC_J:   begin taken = 1; m_tgt = {npc_in[31:28], imemload_in[25:0], 2'b00}; end
        PC_JR:  begin taken = 1; m_tgt = a; end
        default: taken = 0;
      endcase
      m_redir = taken;
      m_tgt_ok = taken;
    end
  endtask

  task automatic check_all();
    check("dREN", {31'd0, dREN_out}, {31'd0, m_dren});
    check("dWEN", {31'd0, dWEN_out}, {31'd0, m_dwen});
    check("WEN", {31'd0, WEN_out}, {31'd0, m_wen});
    check("halt", {31'd0, halt_out}, {31'd0, m_halt});
    check("redirect", {31'd0, redirect_out}, {31'd0, m_redir});
    if (m_data_ok) begin
      check("alu_result", alu_result_out, m_alu);
      check("store_data", store_data_out, m_sd);
      check("npc", npc_out, m_npc);
      check("imemload", imemload_out, m_iml);
      check("lui_word", lui_word_out, m_lui);
      check("wsel", {27'd0, wsel_out}, {27'd0, m_wsel});
      check("wdatsel", {30'd0, wdatsel_out}, {30'd0, m_wdatsel});
    end
    if (m_tgt_ok) check("target", target_out, m_tgt);
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic randomize_inputs();
    imemload_in  = $urandom;
    npc_in       = $urandom;
    rdat1_in     = $urandom;
    rdat2_in     = ($urandom_range(0, 2) == 0) ? rdat1_in : $urandom;
    immediate_in = $urandom;
    lui_word_in  = $urandom;
    exmem_fwd    = $urandom;
    memwb_fwd    = $urandom;
    fwd_a_sel    = 2'($urandom_range(0, 3));
    fwd_b_sel    = (rdat2_in == rdat1_in) ? 2'd0 : 2'($urandom_range(0, 3));
    if (rdat2_in == rdat1_in) fwd_a_sel = 2'd0;
    alusrc_in    = 1'($urandom_range(0, 1));
    dREN_in      = 1'($urandom_range(0, 1));
    dWEN_in      = 1'($urandom_range(0, 1));
    WEN_in       = 1'($urandom_range(0, 1));
    halt_in      = ($urandom_range(0, 29) == 0);
    aluop_in     = aluop_t'($urandom_range(0, 9));
    wsel_in      = 5'($urandom);
    wdatsel_in   = wdatselect_t'($urandom_range(0, 3));
    pc_select_in = pcselect_t'($urandom_range(0, 4));
  endtask

  task automatic set_op(input aluop_t op, input word_t a, input word_t b);
    aluop_in = op;
    rdat1_in = a;
    rdat2_in = b;
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    alusrc_in = 1'b0;
    pc_select_in = PC_NEXT;
  endtask

  initial begin
    // Reset with every input nonzero
    randomize_inputs();
    halt_in = 1'b1;
    enable = 1'b1;
    flush = 1'b1;
    RST = 1'b1;
    step();
    check("rst_alu", alu_result_out, 32'd0);
    check("rst_target", target_out, 32'd0);
    check("rst_redirect", {31'd0, redirect_out}, 32'd0);
    check("rst_wdatsel", {30'd0, wdatsel_out}, 32'd0);

    RST = 1'b0;
    flush = 1'b0;
    enable = 1'b1;
    halt_in = 1'b0;
    WEN_in = 1'b1;

    // ADD with forwarded rt
    set_op(ALU_ADD, 32'd5, 32'd99);
    exmem_fwd = 32'd7;
    fwd_b_sel = 2'd1;
    step();
    check("add_fwd", alu_result_out, 32'd12);
    check("add_store", store_data_out, 32'd7);

    set_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    check("slt_neg", alu_result_out, 32'd1);
    set_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    check("sltu", alu_result_out, 32'd0);
    set_op(ALU_SUB, 32'd0, 32'd1);
    step();
    check("sub_wrap", alu_result_out, 32'hFFFF_FFFF);
    set_op(ALU_SLL, 32'd4, 32'd1);
    step();
    check("sll", alu_result_out, 32'h10);

    // BEQ not taken, then taken
    set_op(ALU_SUB, 32'd3, 32'd4);
    pc_select_in = PC_BEQ;
    npc_in = 32'h100;
    immediate_in = 32'hFFFF_FFFE;
    step();
    check("beq_nt", {31'd0, redirect_out}, 32'd0);
    rdat2_in = 32'd3;
    step();
    check("beq_t", {31'd0, redirect_out}, 32'd1);
    check("beq_tgt", target_out, 32'hF8);

    // Stall: outputs and redirect hold
    enable = 1'b0;
    rdat2_in = 32'd9;
    for (int i = 0; i < 3; i++) step();
    check("stall_redirect", {31'd0, redirect_out}, 32'd1);
    check("stall_tgt", target_out, 32'hF8);

    // Flush beats enable
    enable = 1'b1;
    flush = 1'b1;
    WEN_in = 1'b1;
    pc_select_in = PC_J;
    step();
    check("flush_wen", {31'd0, WEN_out}, 32'd0);
    check("flush_redirect", {31'd0, redirect_out}, 32'd0);
    flush = 1'b0;

    // Halt freezes until reset
    halt_in = 1'b1;
    set_op(ALU_OR, 32'h00F0, 32'h0F00);
    step();
    check("halt_set", {31'd0, halt_out}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      enable = 1'b1;
      flush = 1'($urandom_range(0, 1));
      step();
    end
    check("halt_frozen", alu_result_out, 32'h0FF0);
    RST = 1'b1;
    step();
    check("halt_rst", {31'd0, halt_out}, 32'd0);
    RST = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      RST    = ($urandom_range(0, 39) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipelined MIPS datapath. It consumes the ID/EX latch outputs, forwards operands, runs the ALU and resolves branch/jump targets. Results are registered into the EX/MEM latch, which this block owns. The registered redirect outputs drive the fetch PC mux and the hazard unit's flush logic.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` 32, `regbits_t` 5, `aluop_t`, `pcselect_t`, `wdatselect_t`).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset; one clock, synchronous, active-high. Polarity and synchronicity are fixed.
- `enable` in 1: EX/MEM latch load enable, from the hazard unit.
- `flush` in 1: bubble insert, from the hazard unit.
- `imemload_in`, `npc_in`, `rdat1_in`, `rdat2_in`, `immediate_in`, `lui_word_in` in 32 each: ID/EX outputs.
- `alusrc_in`, `dREN_in`, `dWEN_in`, `WEN_in`, `halt_in` in 1 each: ID/EX controls.
- `aluop_in` in aluop_t.
- `wsel_in` in 5.
- `wdatsel_in` in wdatselect_t.
- `pc_select_in` in pcselect_t.
- `fwd_a_sel`, `fwd_b_sel` in 2 each: operand source select. 0 = rdat, 1 = `exmem_fwd`, 2 = `memwb_fwd`, 3 = rdat.
- `exmem_fwd`, `memwb_fwd` in 32 each: forwarded results.
- `alu_result_out`, `store_data_out`, `npc_out`, `imemload_out`, `lui_word_out` out 32 each: EX/MEM latch outputs.
- `dREN_out`, `dWEN_out`, `WEN_out`, `halt_out` out 1 each.
- `wsel_out` out 5.
- `wdatsel_out` out wdatselect_t.
- `redirect_out` out 1: taken branch or jump, registered.
- `target_out` out 32: redirect PC, registered.

## Operation
- Operand A = `fwd_a_sel` mux over `rdat1_in`.
- Forwarded rt = `fwd_b_sel` mux over `rdat2_in`.
- Operand B = `alusrc_in` ? `immediate_in` : forwarded rt.
- `store_data` = forwarded rt, always.
- ALU operations, 32-bit, carries and overflow discarded:
  - ADD/SUB: wrap mod 2^32.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare → 32'd1 or 32'd0.
  - SLTU: unsigned compare → 32'd1 or 32'd0.
  - SLL/SRL: shift B by A[4:0].
- Branch target = `npc_in` + (`immediate_in` << 2).
- Jump target = {`npc_in`[31:28], `imemload_in`[25:0], 2'b00}.
- Redirect resolution by `pc_select_in`:
  - PC_NEXT: no redirect.
  - PC_BEQ: taken when A == forwarded rt.
  - PC_BNE: taken when A != forwarded rt.
  - PC_J: always taken, jump target.
  - PC_JR: always taken, target = A.
- Latch update priority per rising edge, highest first:
  1. `RST`
  2. sticky halt (`halt_out`=1): no update
  3. `flush`
  4. `enable`
  5. hold
- Flush clears all control outputs (`dREN`, `dWEN`, `WEN`, `halt`, `redirect_out`) to 0. Data outputs may keep any value; the bench must not check them.
- Redirect is only produced when the latch loads. When `enable`=0, `redirect_out` holds its value.

## Timing
- Reset: every output is 0 one edge after `RST`=1. `wdatsel_out`/`pc_select` encodings are 0.
- Latency: inputs sampled at edge N appear on outputs after edge N. The ALU path is combinational within that one cycle.
- `redirect_out`/`target_out` are valid for one cycle per resolved instruction. The hazard unit must flush IF/ID and ID/EX in that cycle.
- Simultaneous events:
  - `flush` and `enable` both high: flush wins.
  - `RST` with anything: reset wins, including clearing a sticky halt.
- Halt: `halt_in`=1 loaded with `enable`=1 sets `halt_out`. The latch then freezes until `RST`.
- `RST` asserted mid-stall clears state at the next edge, regardless of `enable`.

## Test plan
- Reset: drive inputs nonzero, `RST`=1 for one edge → all outputs 0; `redirect_out`=0.
- ADD forwarding: `rdat1_in`=5, `exmem_fwd`=7, `fwd_b_sel`=1, `alusrc_in`=0, aluop ADD, `enable`=1 → `alu_result_out`=12, `store_data_out`=7 after one edge.
- Compare and shift edge cases:
  - SLT A=0xFFFFFFFF, B=1 → 1.
  - SLTU same operands → 0.
  - SUB 0−1 → 0xFFFFFFFF.
  - SLL A=4, B=0x1 → 0x10.
- Branch: BEQ, `npc_in`=0x100, `immediate_in`=0xFFFFFFFE, A=B=3 → `redirect_out`=1, `target_out`=0xF8. Same with A≠B → `redirect_out`=0.
- Stall/flush:
  - `enable`=0 for 3 cycles → outputs held.
  - `flush`=1 with `enable`=1, `WEN_in`=1 → `WEN_out`=0, `redirect_out`=0.
- Halt: load `halt_in`=1, then change inputs for 4 cycles → outputs frozen. Then `RST` → all 0.
